// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-lane data memory controller.
//   size_e  : access size encoding as it appears on the core port
//   state_e : controller sequencing states
//   LANES, ROW_W, ROW_MAX : lane count and row-address geometry
//   size_bytes() : number of bytes touched by an access of a given size
package dmem_pkg;

  localparam int LANES = 4;
  localparam int ROW_W = 14;
  localparam logic [ROW_W-1:0] ROW_MAX = 14'h3FFF;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_e;

  // ILLEGAL reports zero bytes so it can never look like a crossing access
  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      WORD:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : arbitration allowed this cycle (controller idle)
//   req_i[1:0]    : requests, bit 0 = core, bit 1 = loader
//   gnt_o[1:0]    : one-hot grant (combinational)
//   idx_o         : index of the granted requester (0 when nothing granted)
module dmem_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  // ptr_q names the port that wins the next contested cycle
  logic ptr_q;

  // Contested requests go to the pointer; a lone requester always wins
  always_comb begin
    gnt_o = 2'b00;
    idx_o = 1'b0;
    if (en_i) begin
      if (req_i[0] && req_i[1]) begin
        idx_o = ptr_q;
        gnt_o = ptr_q ? 2'b10 : 2'b01;
      end else if (req_i[1]) begin
        idx_o = 1'b1;
        gnt_o = 2'b10;
      end else if (req_i[0]) begin
        gnt_o = 2'b01;
      end
    end
  end

  // After any grant the other port gets priority
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (|gnt_o) begin
      ptr_q <= ~idx_o;
    end
  end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// Sequencer for four 8-bit byte-lane RAMs forming a 64 KiB data memory.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   c_* ports              : core LSU request/response (byte/half/word)
//   l_* ports              : loader request/response (word, unsigned)
//   ram_addr_o             : row address shared by all lanes
//   ram_wren_o             : per-lane write enables
//   ram_wdata_o            : lane-rotated write data
//   ram_rdata_i            : asynchronous lane read data
// Accesses crossing a word boundary take two beats on consecutive rows.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LANES  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [1:0]        c_size_i,
  input  logic              c_unsigned_i,
  input  logic [31:0]       c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [31:0]       c_rdata_o,
  output logic              c_err_o,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [31:0]       l_wdata_i,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [31:0]       l_rdata_o,
  output logic              l_err_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [LANES-1:0]  ram_wren_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  // Byte-lane mask for both beats: low nibble is beat 0, high nibble beat 1
  function automatic logic [7:0] lane_mask(input size_e s, input logic [1:0] off);
    logic [7:0] base;
    base = (8'd1 << size_bytes(s)) - 8'd1;
    return base << off;
  endfunction

  function automatic logic crosses(input size_e s, input logic [1:0] off);
    return ({1'b0, off} + size_bytes(s)) > 3'd4;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[7:0], d[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] rotr_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {d[7:0], d[31:8]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[23:0], d[31:24]};
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input size_e s, input logic uns);
    case (s)
      BYTE:    return {{24{~uns & d[7]}}, d[7:0]};
      HALF:    return {{16{~uns & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        gnt;
  logic              win_idx;
  logic              granted;

  logic              sel_we, sel_uns, sel_err;
  logic [ADDR_W-1:0] sel_addr;
  size_e             sel_size;
  logic [31:0]       sel_wdata;

  logic              we_q, uns_q, err_q, port_q;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic [7:0]        mask_q;
  logic [31:0]       load_result;

  dmem_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == IDLE),
    .req_i  ({l_req_i, c_req_i}),
    .gnt_o  (gnt),
    .idx_o  (win_idx)
  );

  assign granted = |gnt;
  assign c_gnt_o = gnt[0];
  assign l_gnt_o = gnt[1];

  // Fields of the winning requester; the loader is always an unsigned word
  always_comb begin
    sel_we    = win_idx ? l_we_i    : c_we_i;
    sel_addr  = win_idx ? l_addr_i  : c_addr_i;
    sel_size  = win_idx ? WORD      : size_e'(c_size_i);
    sel_uns   = win_idx ? 1'b1      : c_unsigned_i;
    sel_wdata = win_idx ? l_wdata_i : c_wdata_i;
    sel_err   = (sel_size == ILLEGAL)
             || (win_idx && (sel_addr[1:0] != 2'b00))
             || (crosses(sel_size, sel_addr[1:0]) && (sel_addr[ADDR_W-1:2] == ROW_MAX));
  end

  // Request capture at grant and read-lane assembly during the beats
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= BYTE;
      wdata_q <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && granted) begin
        we_q    <= sel_we;
        uns_q   <= sel_uns;
        err_q   <= sel_err;
        port_q  <= win_idx;
        addr_q  <= sel_addr;
        size_q  <= sel_size;
        wdata_q <= sel_wdata;
      end
      // Beat 0 holds lanes off..3, beat 1 supplies the wrapped low lanes
      for (int i = 0; i < LANES; i++) begin
        if (state_q == ACC0 && i >= int'(addr_q[1:0])) begin
          asm_q[8*i +: 8] <= ram_rdata_i[8*i +: 8];
        end
        if (state_q == ACC1 && i < int'(addr_q[1:0])) begin
          asm_q[8*i +: 8] <= ram_rdata_i[8*i +: 8];
        end
      end
    end
  end

  assign mask_q      = lane_mask(size_q, addr_q[1:0]);
  assign load_result = extend(rotr_bytes(asm_q, addr_q[1:0]), size_q, uns_q);

  // Errored requests skip the RAM entirely and answer straight away
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (granted) state_d = sel_err ? RESP : ACC0;
      ACC0:    state_d = crosses(size_q, addr_q[1:0]) ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // RAM beat drive and the one-cycle response on the owning port
  always_comb begin
    ram_addr_o  = '0;
    ram_wren_o  = '0;
    ram_wdata_o = '0;
    c_rvalid_o  = 1'b0;
    c_rdata_o   = '0;
    c_err_o     = 1'b0;
    l_rvalid_o  = 1'b0;
    l_rdata_o   = '0;
    l_err_o     = 1'b0;
    case (state_q)
      ACC0: begin
        ram_addr_o  = addr_q[ADDR_W-1:2];
        ram_wren_o  = we_q ? mask_q[3:0] : 4'b0000;
        ram_wdata_o = rotl_bytes(wdata_q, addr_q[1:0]);
      end
      ACC1: begin
        ram_addr_o  = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
        ram_wren_o  = we_q ? mask_q[7:4] : 4'b0000;
        ram_wdata_o = rotl_bytes(wdata_q, addr_q[1:0]);
      end
      RESP: begin
        if (port_q) begin
          l_rvalid_o = 1'b1;
          l_err_o    = err_q;
          l_rdata_o  = (we_q || err_q) ? 32'd0 : load_result;
        end else begin
          c_rvalid_o = 1'b1;
          c_err_o    = err_q;
          c_rdata_o  = (we_q || err_q) ? 32'd0 : load_result;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Self-checking bench for dmem_lane_ctrl: directed cases from the design
// intent plus randomized traffic against a byte-array memory model.
module tb_dmem_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        c_req, c_we, c_unsigned;
  logic [15:0] c_addr;
  logic [1:0]  c_size;
  logic [31:0] c_wdata;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        l_req, l_we;
  logic [15:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt, l_rvalid, l_err;
  logic [31:0] l_rdata;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wren;
  logic [31:0] ram_wdata, ram_rdata;

  // mem is the physical RAM the DUT drives; ref_mem is the expected contents
  bit [7:0] mem     [0:65535];
  bit [7:0] ref_mem [0:65535];

  int total = 0;
  int bad   = 0;
  bit ptr_m = 1'b0;
  logic [31:0] r;

  always #5 clk = ~clk;

  dmem_lane_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .c_req_i      (c_req),
    .c_we_i       (c_we),
    .c_addr_i     (c_addr),
    .c_size_i     (c_size),
    .c_unsigned_i (c_unsigned),
    .c_wdata_i    (c_wdata),
    .c_gnt_o      (c_gnt),
    .c_rvalid_o   (c_rvalid),
    .c_rdata_o    (c_rdata),
    .c_err_o      (c_err),
    .l_req_i      (l_req),
    .l_we_i       (l_we),
    .l_addr_i     (l_addr),
    .l_wdata_i    (l_wdata),
    .l_gnt_o      (l_gnt),
    .l_rvalid_o   (l_rvalid),
    .l_rdata_o    (l_rdata),
    .l_err_o      (l_err),
    .ram_addr_o   (ram_addr),
    .ram_wren_o   (ram_wren),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
  );

  // Four asynchronous-read byte lanes sharing one row address
  assign ram_rdata = {mem[{ram_addr, 2'd3}], mem[{ram_addr, 2'd2}],
                      mem[{ram_addr, 2'd1}], mem[{ram_addr, 2'd0}]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_wren[i]) mem[{ram_addr, 2'(i)}] <= ram_wdata[8*i +: 8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request on one port, checked beat by beat against the memory model
  task automatic applyStimulus(input bit port, input bit we, input logic [15:0] addr,
                               input logic [1:0] size, input bit uns,
                               input logic [31:0] wd, output logic [31:0] got);
    int n, off, nb, d;
    bit err, seen;
    logic [3:0]  exp_w [2];
    logic [13:0] exp_row [2];
    logic [31:0] val, exp_rd;
    logic [15:0] ba;

    if (port) begin
      size = 2'b10;
      uns  = 1'b1;
    end
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
    off = int'(addr[1:0]);
    err = (size == 2'b11) || (port && off != 0) || (off + n > 4 && addr[15:2] == 14'h3FFF);
    nb  = err ? 0 : ((off + n > 4) ? 2 : 1);
    exp_w[0]   = 4'b0000;
    exp_w[1]   = 4'b0000;
    exp_row[0] = addr[15:2];
    exp_row[1] = addr[15:2] + 14'd1;
    val = 32'd0;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        ba  = addr + 16'(k);
        d   = int'(ba[15:2]) - int'(addr[15:2]);
        if (we) exp_w[d][ba[1:0]] = 1'b1;
        val = val | (32'(ref_mem[ba]) << (8 * k));
      end
    end
    if (size == 2'b00)
      exp_rd = uns ? (val & 32'hFF) : (val[7] ? (val | 32'hFFFFFF00) : val);
    else if (size == 2'b01)
      exp_rd = uns ? (val & 32'hFFFF) : (val[15] ? (val | 32'hFFFF0000) : val);
    else
      exp_rd = val;
    if (we || err) exp_rd = 32'd0;
    if (we && !err)
      for (int k = 0; k < n; k++) ref_mem[addr + 16'(k)] = wd[8*k +: 8];

    got = 32'd0;
    @(negedge clk);
    if (port) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wd;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_size = size;
      c_unsigned = uns; c_wdata = wd;
    end
    #1;
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (port ? l_gnt : c_gnt) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checkOutput("gnt_seen", 32'(seen), 32'd1);
    if (!seen) begin
      c_req = 1'b0;
      l_req = 1'b0;
      return;
    end
    checkOutput("gnt_other", 32'(port ? c_gnt : l_gnt), 32'd0);
    ptr_m = ~port;
    @(posedge clk);
    #1;
    c_req = 1'b0;
    l_req = 1'b0;
    for (int cyc = 1; cyc <= nb + 1; cyc++) begin
      @(negedge clk);
      if (cyc <= nb) begin
        checkOutput("beat_wren", 32'(ram_wren), 32'(exp_w[cyc-1]));
        checkOutput("beat_row", 32'(ram_addr), 32'(exp_row[cyc-1]));
        checkOutput("early_rvalid", 32'(c_rvalid | l_rvalid), 32'd0);
      end else begin
        checkOutput("rvalid", 32'(port ? l_rvalid : c_rvalid), 32'd1);
        checkOutput("rvalid_other", 32'(port ? c_rvalid : l_rvalid), 32'd0);
        checkOutput("rdata", port ? l_rdata : c_rdata, exp_rd);
        checkOutput("err", 32'(port ? l_err : c_err), 32'(err));
        checkOutput("resp_wren", 32'(ram_wren), 32'd0);
        got = port ? l_rdata : c_rdata;
      end
    end
    @(negedge clk);
    checkOutput("rvalid_once", 32'(c_rvalid | l_rvalid), 32'd0);
  endtask

  // Both ports request aligned word stores back to back
  task automatic runBoth(input int count);
    bit seen, win;
    logic [15:0] wa;
    logic [31:0] wv;
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_size = 2'b10; c_unsigned = 1'b0;
    c_addr = 16'h0200 + 16'($urandom_range(0, 63)) * 16'd4; c_wdata = $urandom;
    l_req = 1'b1; l_we = 1'b1;
    l_addr = 16'h0300 + 16'($urandom_range(0, 63)) * 16'd4; l_wdata = $urandom;
    #1;
    for (int t = 0; t < count; t++) begin
      seen = 1'b0;
      for (int w = 0; w < 20; w++) begin
        if (c_gnt || l_gnt) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
      checkOutput("both_gnt_seen", 32'(seen), 32'd1);
      if (!seen) break;
      checkOutput("both_no_overlap", 32'(c_gnt & l_gnt), 32'd0);
      win = l_gnt;
      checkOutput("both_winner", 32'(win), 32'(ptr_m));
      ptr_m = ~win;
      wa = win ? l_addr : c_addr;
      wv = win ? l_wdata : c_wdata;
      for (int k = 0; k < 4; k++) ref_mem[wa + 16'(k)] = wv[8*k +: 8];
      @(posedge clk);
      #1;
      if (t == count - 1) begin
        c_req = 1'b0;
        l_req = 1'b0;
      end else if (win) begin
        l_addr = 16'h0300 + 16'($urandom_range(0, 63)) * 16'd4; l_wdata = $urandom;
      end else begin
        c_addr = 16'h0200 + 16'($urandom_range(0, 63)) * 16'd4; c_wdata = $urandom;
      end
      @(negedge clk);
      checkOutput("both_early_rvalid", 32'(c_rvalid | l_rvalid), 32'd0);
      @(negedge clk);
      checkOutput("both_rvalid", 32'(win ? l_rvalid : c_rvalid), 32'd1);
      checkOutput("both_rvalid_other", 32'(win ? c_rvalid : l_rvalid), 32'd0);
      checkOutput("both_err", 32'(win ? l_err : c_err), 32'd0);
      @(negedge clk);
      #1;
    end
    c_req = 1'b0;
    l_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          port, we, uns;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;

    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_size = '0; c_unsigned = 1'b0; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_flags", 32'({c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, ram_wren}), 32'd0);
    checkOutput("reset_row", 32'(ram_addr), 32'd0);
    checkOutput("reset_wdata", ram_wdata, 32'd0);
    checkOutput("reset_rdata", c_rdata | l_rdata, 32'd0);
    rst_n = 1'b1;

    // Contested traffic right after reset: core, loader, core, loader
    runBoth(4);

    applyStimulus(0, 1, 16'h0010, 2'b10, 0, 32'hDEADBEEF, r);
    checkOutput("word_store_rdata", r, 32'd0);
    applyStimulus(0, 0, 16'h0010, 2'b10, 0, 32'd0, r);
    checkOutput("word_load", r, 32'hDEADBEEF);

    applyStimulus(0, 1, 16'h0023, 2'b01, 0, 32'h000080AA, r);
    checkOutput("half_lane3_row8", 32'(mem[16'h0023]), 32'hAA);
    checkOutput("half_lane0_row9", 32'(mem[16'h0024]), 32'h80);
    applyStimulus(0, 0, 16'h0023, 2'b01, 0, 32'd0, r);
    checkOutput("half_signed", r, 32'hFFFF80AA);
    applyStimulus(0, 0, 16'h0023, 2'b01, 1, 32'd0, r);
    checkOutput("half_unsigned", r, 32'h000080AA);

    applyStimulus(0, 1, 16'h0102, 2'b00, 0, 32'h000000F0, r);
    applyStimulus(0, 0, 16'h0102, 2'b00, 0, 32'd0, r);
    checkOutput("byte_signed", r, 32'hFFFFFFF0);
    applyStimulus(0, 0, 16'h0102, 2'b00, 1, 32'd0, r);
    checkOutput("byte_unsigned", r, 32'h000000F0);

    applyStimulus(0, 0, 16'h0040, 2'b11, 0, 32'd0, r);
    applyStimulus(1, 0, 16'h0006, 2'b10, 1, 32'd0, r);
    applyStimulus(0, 1, 16'hFFFE, 2'b10, 0, 32'h12345678, r);

    // Reset while beat 0 of a crossing core write is on the RAM
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0005; c_size = 2'b10;
    c_unsigned = 1'b0; c_wdata = 32'hCAFEF00D;
    #1;
    checkOutput("rst_case_gnt", 32'(c_gnt), 32'd1);
    @(posedge clk);
    #1;
    c_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_case_acc0_wren", 32'(ram_wren), 32'hE);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_case_flags", 32'({c_gnt, l_gnt, c_rvalid, l_rvalid, c_err, l_err, ram_wren}), 32'd0);
    checkOutput("rst_case_row", 32'(ram_addr), 32'd0);
    checkOutput("rst_case_wdata", ram_wdata, 32'd0);
    checkOutput("rst_case_rdata", c_rdata | l_rdata, 32'd0);
    ptr_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_case_no_rvalid", 32'(c_rvalid | l_rvalid), 32'd0);
    end
    runBoth(1);

    // Randomized traffic, including row-limit and illegal-size corners
    for (int i = 0; i < 80; i++) begin
      port = ($urandom_range(0, 3) == 0);
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                          : 16'($urandom_range(0, 47));
      size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      wd   = $urandom;
      applyStimulus(port, we, addr, size, uns, wd, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
